// File: rtl/load_extend_unit_pkg.sv
// Shared load definitions: load-type codes, FSM states and
// helpers used by the load path, store-mask logic and control.
package load_extend_unit_pkg;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_REQ    = 2'b01,
    S_FINISH = 2'b10
  } state_e;

  // Unknown codes behave as a full-word load.
  function automatic load_type_e norm_type(input logic [2:0] t);
    case (t)
      3'b001:  return LT_LH;
      3'b010:  return LT_LHU;
      3'b011:  return LT_LB;
      3'b100:  return LT_LBU;
      default: return LT_LW;
    endcase
  endfunction

  // Bytes never misalign; halves need even, words need 4-byte.
  function automatic logic is_misaligned(
    input load_type_e t,
    input logic [1:0] off
  );
    case (t)
      LT_LH, LT_LHU: return off[0];
      LT_LB, LT_LBU: return 1'b0;
      default:       return |off;
    endcase
  endfunction

endpackage

// File: rtl/load_lane_extract.sv
// Big-endian lane select and sign/zero extension of a load word.
// Ports: word_i, offset_i, type_i in; value_o 32-bit result out.
module load_lane_extract
  import load_extend_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  load_type_e  type_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[31:24];
    case (offset_i)
      2'd0: byte_sel = word_i[31:24];
      2'd1: byte_sel = word_i[23:16];
      2'd2: byte_sel = word_i[15:8];
      2'd3: byte_sel = word_i[7:0];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[15:0] : word_i[31:16];
  end

  always_comb begin
    value_o = word_i;
    case (type_i)
      LT_LB:   value_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  value_o = {24'h0, byte_sel};
      LT_LH:   value_o = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  value_o = {16'h0, half_sel};
      default: value_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_extend_unit.sv
// Load unit: captures a load, issues one memory read with timeout,
// extends the returned lane. Ports: CLK/RST, START/LOAD_TYPE/ADDR
// request, MEM_* memory side, O/DONE/BUSY/MISALIGNED/TIMED_OUT.
module load_extend_unit
  import load_extend_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [2:0]  LOAD_TYPE,
  input  logic [31:0] ADDR,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_READY,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] O,
  output logic        DONE,
  output logic        BUSY,
  output logic        MISALIGNED,
  output logic        TIMED_OUT
);

  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW = (CW_RAW > 4) ? CW_RAW : 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_e      state_q;
  load_type_e  type_q;
  logic [31:0] addr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [31:0] o_q;
  logic        req_q;
  logic        done_q;
  logic        busy_q;
  logic        mis_q;
  logic        to_q;
  logic [31:0] lane_val;
  load_type_e  type_in;

  assign type_in = norm_type(LOAD_TYPE);
  assign cnt_d   = cnt_q + 1'b1;

  load_lane_extract u_extract (
    .word_i   (MEM_RDATA),
    .offset_i (addr_q[1:0]),
    .type_i   (type_q),
    .value_o  (lane_val)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      type_q  <= LT_LW;
      addr_q  <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      to_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            type_q <= type_in;
            addr_q <= ADDR;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (is_misaligned(type_in, ADDR[1:0])) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // Data on the final counted cycle still wins.
          if (MEM_READY) begin
            state_q <= S_FINISH;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            o_q     <= lane_val;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_MAX) begin
              state_q <= S_FINISH;
              req_q   <= 1'b0;
              done_q  <= 1'b1;
              to_q    <= 1'b1;
              o_q     <= '0;
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_REQ    = req_q;
  assign MEM_ADDR   = {addr_q[31:2], 2'b00};
  assign O          = o_q;
  assign DONE       = done_q;
  assign BUSY       = busy_q;
  assign MISALIGNED = mis_q;
  assign TIMED_OUT  = to_q;

endmodule
